// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, BURST, DRAIN} fetch_state_t;

    localparam logic       READ   = 1'b1;
    localparam logic [3:0] MEMORY = 4'b0001;
    localparam logic [12:0] REQ_TAG = {READ, MEMORY, 8'b0};

    localparam int LINE_BYTES = 64;
    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte queue: 0..8 byte write port per beat, WIN_BYTES read window for the decoder.
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128,
    parameter int WIN_BYTES = 15,
    localparam int PW = $clog2(BUF_BYTES) + 1,
    localparam int AW = $clog2(WIN_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [63:0]            wr_data,
    input  logic [3:0]             wr_lo,
    input  logic [AW-1:0]          consume,
    output logic [PW-1:0]          occ,
    output logic [WIN_BYTES*8-1:0] win_bytes,
    output logic [AW-1:0]          win_avail
);
    localparam int IW = PW - 1;

    logic [7:0]    mem [BUF_BYTES];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [IW-1:0] wr_idx [BEAT_BYTES];
    logic [IW-1:0] rd_idx [WIN_BYTES];
    logic [BEAT_BYTES-1:0] wr_keep;
    logic [3:0]    wr_len;

    // Beat bytes below wr_lo are dropped; the rest pack down to wr_ptr in order.
    always_comb begin
        wr_len = 4'(BEAT_BYTES) - wr_lo;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            wr_keep[k] = wr_en && (4'(k) >= wr_lo);
            wr_idx[k]  = wr_ptr[IW-1:0] + IW'(k) - IW'(wr_lo);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < BEAT_BYTES; k++)
            if (wr_keep[k]) mem[wr_idx[k]] <= wr_data[63-8*k -: 8];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(consume);
            if (wr_en) wr_ptr <= wr_ptr + PW'(wr_len);
        end
    end

    assign occ = wr_ptr - rd_ptr;

    always_comb begin
        win_avail = (occ > PW'(WIN_BYTES)) ? AW'(WIN_BYTES) : occ[AW-1:0];
        for (int i = 0; i < WIN_BYTES; i++) begin
            rd_idx[i] = rd_ptr[IW-1:0] + IW'(i);
            win_bytes[i*8 +: 8] = (AW'(i) < win_avail) ? mem[rd_idx[i]] : 8'h00;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: line requests on the system bus, beat collection, redirect/drain handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128,
    parameter int WIN_BYTES = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [63:0]                          entry,
    input  logic                                 redirect_valid,
    input  logic [63:0]                          redirect_rip,
    output logic                                 reqcyc,
    output logic [63:0]                          req,
    output logic [12:0]                          reqtag,
    input  logic                                 reqack,
    input  logic                                 respcyc,
    input  logic [63:0]                          resp,
    output logic                                 respack,
    output logic [WIN_BYTES*8-1:0]               dec_bytes,
    output logic [$clog2(WIN_BYTES+1)-1:0]       dec_avail,
    input  logic [$clog2(WIN_BYTES+1)-1:0]       dec_consume
);
    localparam int PW = $clog2(BUF_BYTES) + 1;
    localparam logic [PW-1:0] REQ_LIMIT = PW'(BUF_BYTES - LINE_BYTES);

    fetch_state_t  state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [63:0]   line_addr, line_n;
    logic [5:0]    skip, skip_n;
    logic          flush, beat_we;
    logic [3:0]    beat_lo;
    logic [6:0]    beat_base, skip_rem;
    logic [PW-1:0] occ;

    assign respack = respcyc;

    // Number of leading bytes of the current beat that fall below the entry offset.
    always_comb begin
        beat_base = {1'b0, cnt, 3'b000};
        skip_rem  = {1'b0, skip} - beat_base;
        if ({1'b0, skip} <= beat_base) beat_lo = 4'd0;
        else if (skip_rem >= 7'd8)     beat_lo = 4'd8;
        else                           beat_lo = skip_rem[3:0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        line_n  = line_addr;
        skip_n  = skip;
        flush   = 1'b0;
        beat_we = 1'b0;
        case (state)
            IDLE:  if (occ <= REQ_LIMIT) state_n = REQ;
            REQ:   if (reqack) begin
                       state_n = WAIT;
                       cnt_n   = 3'd0;
                   end
            WAIT:  if (respcyc) begin
                       state_n = BURST;
                       beat_we = 1'b1;
                       cnt_n   = cnt + 3'd1;
                   end
            BURST: if (respcyc) begin
                       beat_we = 1'b1;
                       cnt_n   = cnt + 3'd1;
                       if (cnt == 3'd7) begin
                           state_n = IDLE;
                           line_n  = line_addr + 64'(LINE_BYTES);
                           skip_n  = '0;
                       end
                   end
            DRAIN: if (respcyc) begin
                       cnt_n = cnt + 3'd1;
                       if (cnt == 3'd7) state_n = IDLE;
                   end
            default: state_n = IDLE;
        endcase
        // An acked request cannot be cancelled, so its beats are drained before refetching.
        if (redirect_valid) begin
            flush   = 1'b1;
            beat_we = 1'b0;
            line_n  = {redirect_rip[63:6], 6'b0};
            skip_n  = redirect_rip[5:0];
            case (state)
                IDLE, REQ: begin
                    state_n = (state == REQ && reqack) ? DRAIN : IDLE;
                    cnt_n   = 3'd0;
                end
                WAIT, BURST: state_n = (respcyc && cnt == 3'd7) ? IDLE : DRAIN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            line_addr <= {entry[63:6], 6'b0};
            skip      <= entry[5:0];
            reqcyc    <= 1'b0;
            req       <= '0;
            reqtag    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            line_addr <= line_n;
            skip      <= skip_n;
            reqcyc    <= (state_n == REQ);
            req       <= (state_n == REQ) ? line_n : '0;
            reqtag    <= (state_n == REQ) ? REQ_TAG : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (dec_consume <= dec_avail)
                else $fatal(1, "fetch_unit: dec_consume exceeds dec_avail");
            assert (!(respcyc && (state == IDLE || state == REQ)))
                else $fatal(1, "fetch_unit: response beat with no request outstanding");
        end
    end

    fetch_byte_queue #(.BUF_BYTES(BUF_BYTES), .WIN_BYTES(WIN_BYTES)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (beat_we),
        .wr_data   (resp),
        .wr_lo     (beat_lo),
        .consume   (redirect_valid ? '0 : dec_consume),
        .occ       (occ),
        .win_bytes (dec_bytes),
        .win_avail (dec_avail)
    );

endmodule
